memory_arbiter: RTL

Sequences the shared LC-3 memory through `memory_control` on behalf of two requesters: port 0 for instruction fetch and port 1 for data load/store. It generates the LD_MAR, LD_MDR, R.W and MIO.EN control strobes and drives the address and write data onto the CPU bus. It waits on the memory ready bit and returns read data plus a one-cycle acknowledge to the winning requester. Arbitration is round-robin, and a watchdog counter converts a hung memory access into an error acknowledge.

---
 rtl/memory_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Round-robin arbiter that sequences the shared LC-3 memory through
// memory_control for two requesters (port 0 = fetch, port 1 = data).
// Ports:
//   i_CLK, i_RST_N                 clock, async active-low reset
//   i_Req*/i_RW*/i_Addr*/i_WData*  requester inputs (RW 1 = write)
//   o_Ack0/o_Ack1, o_Err, o_RData  one-cycle completion, timeout flag, read data
//   o_Busy                         high whenever not IDLE
//   o_LD_MAR/o_LD_MDR/o_RW/o_MIO_EN strobes to memory_control
//   o_Bus/o_Bus_EN                 value offered to the CPU bus and its gate
//   i_Mem_Bus/i_Ready              MDR contents and memory ready bit
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request; grant and latch on the way out
// MAR   | drive address, load MAR
// MDR   | drive write data, load MDR (writes only)
// READ  | memory enabled for read, wait for ready
// WRITE | memory enabled for write, wait for ready
// DONE  | ack to the latched port with read data
// ERR   | ack to the latched port with error flag (watchdog expired)
module memory_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        i_CLK,
   input  logic        i_RST_N,
   input  logic        i_Req0,
   input  logic        i_Req1,
   input  logic        i_RW0,
   input  logic        i_RW1,
   input  logic [15:0] i_Addr0,
   input  logic [15:0] i_Addr1,
   input  logic [15:0] i_WData0,
   input  logic [15:0] i_WData1,
   output logic        o_Ack0,
   output logic        o_Ack1,
   output logic        o_Err,
   output logic [15:0] o_RData,
   output logic        o_Busy,
   output logic        o_LD_MAR,
   output logic        o_LD_MDR,
   output logic        o_RW,
   output logic        o_MIO_EN,
   output logic [15:0] o_Bus,
   output logic        o_Bus_EN,
   input  logic [15:0] i_Mem_Bus,
   input  logic        i_Ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAR   = 3'd1,
      S_MDR   = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   localparam logic       WDOG_EN     = (TIMEOUT != 0);

   state_t      state, state_nxt;
   logic        last_grant;
   logic        port_q;
   logic        rw_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [7:0]  wait_cnt;
   logic        any_req;
   logic        grant;
   logic        timeout_hit;

   assign any_req = i_Req0 | i_Req1;

   // On a tie the port that did not win last time gets the grant.
   assign grant = (i_Req0 && i_Req1) ? ~last_grant : i_Req1;

   // Ready in the same cycle takes priority over the watchdog.
   assign timeout_hit = WDOG_EN && (wait_cnt == TIMEOUT_CNT) && !i_Ready;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         port_q     <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && any_req) begin
            port_q  <= grant;
            rw_q    <= grant ? i_RW1    : i_RW0;
            addr_q  <= grant ? i_Addr1  : i_Addr0;
            wdata_q <= grant ? i_WData1 : i_WData0;
         end
         if (state == S_DONE || state == S_ERR)
            last_grant <= port_q;
         // READ/WRITE are only entered from MAR or MDR, so clearing there
         // gives a fresh count on every entry.
         if (state == S_MAR || state == S_MDR)
            wait_cnt <= '0;
         else if ((state == S_READ || state == S_WRITE) && !i_Ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_MAR;
         S_MAR:   state_nxt = rw_q ? S_MDR : S_READ;
         S_MDR:   state_nxt = S_WRITE;
         S_READ,
         S_WRITE: begin
            if (i_Ready)          state_nxt = S_DONE;
            else if (timeout_hit) state_nxt = S_ERR;
         end
         S_DONE,
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_Ack0   = 1'b0;
      o_Ack1   = 1'b0;
      o_Err    = 1'b0;
      o_RData  = '0;
      o_Busy   = (state != S_IDLE);
      o_LD_MAR = 1'b0;
      o_LD_MDR = 1'b0;
      o_RW     = 1'b0;
      o_MIO_EN = 1'b0;
      o_Bus    = '0;
      o_Bus_EN = 1'b0;
      case (state)
         S_MAR: begin
            o_Bus    = addr_q;
            o_Bus_EN = 1'b1;
            o_LD_MAR = 1'b1;
         end
         S_MDR: begin
            o_Bus    = wdata_q;
            o_Bus_EN = 1'b1;
            o_LD_MDR = 1'b1;
         end
         S_READ: begin
            o_MIO_EN = 1'b1;
            o_LD_MDR = i_Ready;
         end
         S_WRITE: begin
            o_MIO_EN = 1'b1;
            o_RW     = 1'b1;
         end
         S_DONE: begin
            o_Ack0  = ~port_q;
            o_Ack1  = port_q;
            o_RData = rw_q ? 16'h0000 : i_Mem_Bus;
         end
         S_ERR: begin
            o_Ack0 = ~port_q;
            o_Ack1 = port_q;
            o_Err  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
